// File: rtl/econ_out_frame_tx.sv
// Framed narrow-link transmitter: buffers wide result vectors and re-emits each one
// as a sync/sequence header word followed by its data words, least-significant word first.
module econ_out_frame_tx #(
    parameter int unsigned IN_W       = 80,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned NWORDS     = IN_W / OUT_W,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [7:0]  SYNC       = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_dat,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [OUT_W-1:0] tx_dat,
    output logic             tx_vld,
    input  logic             tx_rdy,
    output logic             tx_sof,
    output logic             tx_eof,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0]      K_LAST = KW'(NWORDS - 1);
    localparam logic [OUT_W-9:0]   SYNC_W = (OUT_W - 8)'(SYNC);
    localparam logic [CW-1:0]      FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t           state;
    logic [IN_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_inc;
    logic [7:0]       seq;
    logic [7:0]       seq_inc;
    logic [OUT_W-1:0] head_w [NWORDS];
    logic             push;
    logic             pop;

    assign push      = in_vld && in_rdy;
    assign pop       = (state == DATA) && tx_vld && tx_rdy && (k == K_LAST);
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign k_inc     = k + KW'(1);
    assign seq_inc   = seq + 8'd1;

    // Head vector split into link words, word 0 = least-significant slice.
    always_comb begin
        for (int i = 0; i < int'(NWORDS); i++) begin
            head_w[i] = mem[rd_ptr][i*OUT_W +: OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // in_rdy is registered from the updated occupancy, so a full FIFO stays
    // closed for the whole cycle even when a pop frees a slot at its end.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            in_rdy <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count  <= count_nxt;
            in_rdy <= (count_nxt != FULL_CNT);
        end
    end

    // Framing FSM; the next word is loaded on the same edge the current one transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            seq       <= '0;
            frame_cnt <= '0;
            tx_dat    <= '0;
            tx_vld    <= 1'b0;
            tx_sof    <= 1'b0;
            tx_eof    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (!tx_vld) begin
                        tx_vld <= 1'b1;
                        tx_sof <= 1'b1;
                        tx_eof <= 1'b0;
                        tx_dat <= {SYNC_W, seq};
                    end else if (tx_rdy) begin
                        state  <= DATA;
                        k      <= '0;
                        tx_sof <= 1'b0;
                        tx_eof <= (K_LAST == '0);
                        tx_dat <= head_w[0];
                    end
                end
                DATA: begin
                    if (tx_vld && tx_rdy) begin
                        if (k == K_LAST) begin
                            seq <= seq_inc;
                            if (frame_cnt != 16'hFFFF) begin
                                frame_cnt <= frame_cnt + 16'd1;
                            end
                            tx_eof <= 1'b0;
                            if (count_nxt != '0) begin
                                state  <= HDR;
                                tx_sof <= 1'b1;
                                tx_dat <= {SYNC_W, seq_inc};
                            end else begin
                                state  <= IDLE;
                                tx_vld <= 1'b0;
                                tx_sof <= 1'b0;
                                tx_dat <= '0;
                            end
                        end else begin
                            k      <= k_inc;
                            tx_eof <= (k_inc == K_LAST);
                            tx_dat <= head_w[k_inc];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_econ_out_frame_tx.sv
// Directed bench for econ_out_frame_tx: expected frames come from a hand-filled table,
// a negedge monitor captures transferred words and checks hold-stability during stalls.
module tb_econ_out_frame_tx;

    typedef struct {
        logic [79:0] dat;
        logic [15:0] w [6];
    } vec_t;

    typedef struct packed {
        logic [15:0] dat;
        logic        sof;
        logic        eof;
        logic [31:0] cyc;
    } wd_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [79:0] in_dat = '0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [15:0] tx_dat;
    logic        tx_vld;
    logic        tx_rdy = 1'b0;
    logic        tx_sof;
    logic        tx_eof;
    logic [15:0] frame_cnt;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tbl [3];
    wd_t  cap [$];

    logic [31:0] cyc = '0;
    logic        stall_q = 1'b0;
    logic [15:0] p_dat = '0;
    logic        p_sof = 1'b0;
    logic        p_eof = 1'b0;

    always #5 clk = ~clk;

    econ_out_frame_tx dut (
        .clk       (clk),
        .reset     (reset),
        .in_dat    (in_dat),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .tx_dat    (tx_dat),
        .tx_vld    (tx_vld),
        .tx_rdy    (tx_rdy),
        .tx_sof    (tx_sof),
        .tx_eof    (tx_eof),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Words transfer on the next posedge when tx_vld && tx_rdy at this negedge.
    always @(negedge clk) begin
        cyc = cyc + 32'd1;
        if (!reset && stall_q) begin
            chk("stall_vld", 32'(tx_vld), 32'd1);
            chk("stall_dat", 32'(tx_dat), 32'(p_dat));
            chk("stall_sof", 32'(tx_sof), 32'(p_sof));
            chk("stall_eof", 32'(tx_eof), 32'(p_eof));
        end
        if (!reset && tx_vld && tx_rdy) begin
            cap.push_back('{dat: tx_dat, sof: tx_sof, eof: tx_eof, cyc: cyc});
        end
        stall_q = !reset && tx_vld && !tx_rdy;
        p_dat   = tx_dat;
        p_sof   = tx_sof;
        p_eof   = tx_eof;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [79:0] d);
        int n = 0;
        in_dat = d;
        in_vld = 1'b1;
        while (!in_rdy && n < 200) begin
            tick();
            n++;
        end
        chk("push_rdy", 32'(in_rdy), 32'd1);
        tick();
        in_vld = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (cap.size() < n && t < 2000) begin
            tick();
            t++;
        end
        chk("wait_words", 32'(cap.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input int base, input int vi, input string tag);
        for (int i = 0; i < 6; i++) begin
            if (base + i < cap.size()) begin
                chk($sformatf("%s_dat%0d", tag, i), 32'(cap[base+i].dat), 32'(tbl[vi].w[i]));
                chk($sformatf("%s_sof%0d", tag, i), 32'(cap[base+i].sof), 32'(i == 0));
                chk($sformatf("%s_eof%0d", tag, i), 32'(cap[base+i].eof), 32'(i == 5));
            end else begin
                chk($sformatf("%s_missing%0d", tag, i), 32'd0, 32'd1);
            end
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        in_vld = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        cap.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1);
    end

    initial begin
        int t;
        int n_eof;

        tbl[0].dat = 80'h0009_0008_0007_0006_0005;
        tbl[0].w   = '{16'hA500, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009};
        tbl[1].dat = 80'h1234_5678_9ABC_DEF0_0F1E;
        tbl[1].w   = '{16'hA501, 16'h0F1E, 16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
        tbl[2].dat = 80'hFFFF_0000_AAAA_5555_C3C3;
        tbl[2].w   = '{16'hA502, 16'hC3C3, 16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF};

        // Reset values, then in_rdy rises one cycle after release.
        tx_rdy = 1'b1;
        reset  = 1'b1;
        tick();
        tick();
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_tx_vld", 32'(tx_vld), 32'd0);
        chk("rst_tx_sof", 32'(tx_sof), 32'd0);
        chk("rst_tx_eof", 32'(tx_eof), 32'd0);
        chk("rst_tx_dat", 32'(tx_dat), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        tick();
        chk("rel_in_rdy", 32'(in_rdy), 32'd1);
        cap.delete();

        // Single frame and its two-cycle header latency.
        push_vec(tbl[0].dat);
        chk("t1_lat0_vld", 32'(tx_vld), 32'd0);
        tick();
        chk("t1_lat1_vld", 32'(tx_vld), 32'd0);
        tick();
        chk("t1_lat2_vld", 32'(tx_vld), 32'd1);
        chk("t1_lat2_dat", 32'(tx_dat), 32'h0000_A500);
        chk("t1_lat2_sof", 32'(tx_sof), 32'd1);
        wait_words(6);
        tick();
        tick();
        check_frame(0, 0, "t1");
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);

        // Three back-to-back frames, no idle gaps.
        do_reset();
        push_vec(tbl[0].dat);
        push_vec(tbl[1].dat);
        chk("t2_full_rdy", 32'(in_rdy), 32'd0);
        push_vec(tbl[2].dat);
        wait_words(18);
        tick();
        tick();
        for (int f = 0; f < 3; f++) begin
            check_frame(f * 6, f, $sformatf("t2f%0d", f));
        end
        for (int i = 1; i < 18 && i < cap.size(); i++) begin
            chk($sformatf("t2_gap%0d", i), cap[i].cyc - cap[i-1].cyc, 32'd1);
        end
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd3);

        // Alternating tx_rdy with two 10-cycle stalls inside the frame.
        do_reset();
        tx_rdy = 1'b0;
        push_vec(tbl[0].dat);
        for (int c = 0; c < 50; c++) begin
            tx_rdy = ((c >= 4 && c < 14) || (c >= 16 && c < 26)) ? 1'b0 : c[0];
            tick();
        end
        tx_rdy = 1'b1;
        tick();
        tick();
        chk("t3_words", 32'(cap.size()), 32'd6);
        check_frame(0, 0, "t3");

        // 257 frames: sequence wraps to 0 on frame 256.
        do_reset();
        tx_rdy = 1'b1;
        for (int i = 0; i < 257; i++) begin
            push_vec(80'(i));
        end
        t = 0;
        while (frame_cnt != 16'd257 && t < 300) begin
            tick();
            t++;
        end
        tick();
        chk("t4_frame_cnt", 32'(frame_cnt), 32'd257);
        chk("t4_words", 32'(cap.size()), 32'd1542);
        chk("t4_hdr255", 32'(cap[255*6].dat), 32'h0000_A5FF);
        chk("t4_hdr256", 32'(cap[256*6].dat), 32'h0000_A500);
        chk("t4_sof256", 32'(cap[256*6].sof), 32'd1);
        chk("t4_w0_256", 32'(cap[256*6+1].dat), 32'h0000_0100);

        // Reset after the third data word with a second vector queued.
        do_reset();
        tx_rdy = 1'b1;
        push_vec(tbl[0].dat);
        push_vec(tbl[1].dat);
        wait_words(4);
        reset = 1'b1;
        tick();
        chk("t5_rst_vld", 32'(tx_vld), 32'd0);
        chk("t5_rst_rdy", 32'(in_rdy), 32'd0);
        chk("t5_rst_cnt", 32'(frame_cnt), 32'd0);
        n_eof = 0;
        foreach (cap[i]) begin
            if (cap[i].eof) n_eof++;
        end
        chk("t5_no_eof", 32'(n_eof), 32'd0);
        reset = 1'b0;
        tick();
        cap.delete();
        for (int c = 0; c < 20; c++) tick();
        chk("t5_fifo_cleared", 32'(cap.size()), 32'd0);
        push_vec(tbl[0].dat);
        wait_words(6);
        tick();
        tick();
        check_frame(0, 0, "t5");
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);

        // in_vld held with changing data while full and stalled.
        do_reset();
        tx_rdy = 1'b0;
        in_vld = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_dat = (c == 0) ? tbl[0].dat :
                     (c == 1) ? tbl[1].dat : {16'(c), 64'hDEAD_BEEF_CAFE_F00D};
            tick();
        end
        in_vld = 1'b0;
        chk("t6_full_rdy", 32'(in_rdy), 32'd0);
        chk("t6_hold_vld", 32'(tx_vld), 32'd1);
        chk("t6_hold_sof", 32'(tx_sof), 32'd1);
        tx_rdy = 1'b1;
        wait_words(12);
        for (int c = 0; c < 10; c++) tick();
        chk("t6_words", 32'(cap.size()), 32'd12);
        check_frame(0, 0, "t6a");
        check_frame(6, 1, "t6b");
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
